// File: rtl/if_id_fetch_stage_if.sv
// Purpose : bundles the fetch-stage control inputs, imem port and IF/ID outputs.
// Latency : none (wires only).
// Backpressure: the stall input freezes the stage; there is no ready/valid return path.
// Modports: master = the fetch stage, slave = the ID stage / imem / hazard unit side.
// Optional: IF_PERF_CNT_EN adds the perf_fetch / perf_bubble counter signals.
interface if_id_fetch_stage_if;
    logic        stall;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_bubble;
`endif

    modport master (
        input  stall, pcsource, bpc, jpc, imem_rdata,
        output imem_addr, pc, if_id_inst, if_id_pc4, if_id_valid, halted
`ifdef IF_PERF_CNT_EN
        , output perf_fetch, perf_bubble
`endif
    );

    modport slave (
        output stall, pcsource, bpc, jpc, imem_rdata,
        input  imem_addr, pc, if_id_inst, if_id_pc4, if_id_valid, halted
`ifdef IF_PERF_CNT_EN
        , input perf_fetch, perf_bubble
`endif
    );
endinterface

// File: rtl/if_id_fetch_stage.sv
// Purpose : CPCPU4 instruction fetch (PC + next-PC select) and IF/ID pipeline register.
// Latency : instruction at pc=A appears on if_id_* one cycle later; redirects cost one bubble.
// Backpressure: stall holds PC and IF/ID; an illegal pcsource halts the stage until rst.
// Ports   : clk, rst (sync, active-high); fif (master) carries stall/pcsource/bpc/jpc,
//           imem_addr/imem_rdata, pc, if_id_inst/pc4/valid and halted.
// Optional: define IF_PERF_CNT_EN for perf_fetch / perf_bubble counters on the interface.
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    if_id_fetch_stage_if.master fif
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        A_HOLD  = 2'd0,
        A_FETCH = 2'd1,
        A_REDIR = 2'd2,
        A_HALT  = 2'd3
    } act_t;

    state_t      state;
    state_t      state_nxt;
    act_t        act;

    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] pc4_q;
    logic        valid_q;
    logic        halted_q;

    logic [31:0] pc_plus4;
    logic        halt_req;
    logic        redir_req;
    logic [31:0] redir_tgt;

    // ID-side requests only count when the IF/ID slot holds a real instruction.
    assign pc_plus4  = pc_q + 32'd4;
    assign halt_req  = valid_q && (fif.pcsource == 2'b11) && !fif.stall;
    assign redir_req = valid_q && (fif.pcsource[1] ^ fif.pcsource[0]);
    assign redir_tgt = (fif.pcsource == 2'b01) ? (fif.bpc & ~32'h3) : (fif.jpc & ~32'h3);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT:  state_nxt = S_RUN;
            S_RUN:   if (halt_req) state_nxt = S_HALT;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_BOOT;
        endcase
    end

    // Output decode: one datapath action per cycle, in priority order
    // halt > stall > redirect > sequential. BOOT always performs the first fetch.
    always_comb begin
        act = A_HOLD;
        case (state)
            S_BOOT: act = A_FETCH;
            S_RUN: begin
                if (halt_req)       act = A_HALT;
                else if (fif.stall) act = A_HOLD;
                else if (redir_req) act = A_REDIR;
                else                act = A_FETCH;
            end
            default: act = A_HOLD;
        endcase
    end

    // PC and IF/ID register. A bubble clears valid and loads NOP_INST; pc4 is
    // left as-is because it is meaningless without valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            inst_q   <= NOP_INST;
            pc4_q    <= 32'd0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (act)
                A_FETCH: begin
                    pc_q    <= pc_plus4;
                    inst_q  <= fif.imem_rdata;
                    pc4_q   <= pc_plus4;
                    valid_q <= 1'b1;
                end
                A_REDIR: begin
                    pc_q    <= redir_tgt;
                    inst_q  <= NOP_INST;
                    valid_q <= 1'b0;
                end
                A_HALT: begin
                    inst_q   <= NOP_INST;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_bubble_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q  <= 32'd0;
            perf_bubble_q <= 32'd0;
        end else begin
            if (act == A_FETCH) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if ((act == A_REDIR) || (act == A_HALT)) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
        end
    end

    assign fif.perf_fetch  = perf_fetch_q;
    assign fif.perf_bubble = perf_bubble_q;
`endif

    assign fif.imem_addr   = pc_q;
    assign fif.pc          = pc_q;
    assign fif.if_id_inst  = inst_q;
    assign fif.if_id_pc4   = pc4_q;
    assign fif.if_id_valid = valid_q;
    assign fif.halted      = halted_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Purpose : self-checking bench for if_id_fetch_stage (directed steps + random run vs a reference model).
// Latency : outputs are sampled 1 time unit after each rising edge.
// Backpressure: stall / halt exercised via stimulus; no waits on DUT events.
module tb_if_id_fetch_stage;

    logic clk;
    logic rst_a;
    logic rst_b;

    int n_cmp;
    int n_fail;

    logic [31:0] imem [0:255];

    if_id_fetch_stage_if ifa ();
    if_id_fetch_stage_if ifb ();

    if_id_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0000)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .fif (ifa)
    );

    if_id_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(32'h0000_0000)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .fif (ifb)
    );

    assign ifa.imem_rdata = imem[ifa.imem_addr[9:2]];
    assign ifb.imem_rdata = imem[ifb.imem_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state for dut_a: what the ID stage should see.
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_halted;
    logic        m_first;     // next cycle is the first fetch after reset
    logic [31:0] m_pf;
    logic [31:0] m_pb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic m_fetch();
        m_inst  = imem[m_pc[9:2]];
        m_pc    = m_pc + 32'd4;
        m_pc4   = m_pc;
        m_valid = 1'b1;
        m_pf    = m_pf + 32'd1;
    endtask

    task automatic m_bubble();
        m_inst  = 32'h0;
        m_valid = 1'b0;
        m_pb    = m_pb + 32'd1;
    endtask

    // Apply one clock of the spec's rules to the model, from inputs as currently driven.
    task automatic model_step();
        if (rst_a) begin
            m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_halted = 1'b0; m_first = 1'b1; m_pf = 32'h0; m_pb = 32'h0;
        end else if (m_halted) begin
            // frozen until reset
        end else if (m_first) begin
            m_fetch();
            m_first = 1'b0;
        end else if (m_valid && ifa.pcsource == 2'd3 && !ifa.stall) begin
            m_bubble();
            m_halted = 1'b1;
        end else if (ifa.stall) begin
            // hold
        end else if (m_valid && ifa.pcsource == 2'd1) begin
            m_pc = {ifa.bpc[31:2], 2'b00};
            m_bubble();
        end else if (m_valid && ifa.pcsource == 2'd2) begin
            m_pc = {ifa.jpc[31:2], 2'b00};
            m_bubble();
        end else begin
            m_fetch();
        end
    endtask

    task automatic check_a();
        chk("pc", ifa.pc, m_pc);
        chk("imem_addr", ifa.imem_addr, m_pc);
        chk("valid", {31'b0, ifa.if_id_valid}, {31'b0, m_valid});
        chk("inst", ifa.if_id_inst, m_inst);
        if (m_valid) chk("pc4", ifa.if_id_pc4, m_pc4);
        chk("halted", {31'b0, ifa.halted}, {31'b0, m_halted});
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch", ifa.perf_fetch, m_pf);
        chk("perf_bubble", ifa.perf_bubble, m_pb);
`endif
    endtask

    task automatic tick_a();
        model_step();
        @(posedge clk);
        #1;
        check_a();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic st, input logic [1:0] ps, input logic [31:0] b, input logic [31:0] j);
        ifa.stall = st; ifa.pcsource = ps; ifa.bpc = b; ifa.jpc = j;
    endtask

    initial begin
        logic [31:0] frozen_pc;
        int          r;
        n_cmp = 0;
        n_fail = 0;
        for (int i = 0; i < 256; i++) imem[i] = 32'(i + 1);
        m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_halted = 1'b0; m_first = 1'b1; m_pf = 32'h0; m_pb = 32'h0;

        rst_b = 1'b1;
        ifb.stall = 1'b0; ifb.pcsource = 2'd0; ifb.bpc = 32'h0; ifb.jpc = 32'h0;
        set_a(1'b0, 2'd0, 32'h0, 32'h0);

        // Reset
        rst_a = 1'b1;
        tick_a();
        tick_a();
        chk("rst_pc", ifa.pc, 32'h0);
        chk("rst_valid", {31'b0, ifa.if_id_valid}, 32'h0);
        rst_a = 1'b0;

        // Free-running fetch up to pc=8
        tick_a();
        chk("boot_inst", ifa.if_id_inst, 32'h1);
        tick_a();
        chk("seq_pc8", ifa.pc, 32'h8);

        // Two stall cycles at pc=8
        set_a(1'b1, 2'd0, 32'h0, 32'h0);
        tick_a();
        tick_a();
        chk("stall_pc", ifa.pc, 32'h8);
        chk("stall_inst", ifa.if_id_inst, 32'h2);
        chk("stall_pc4", ifa.if_id_pc4, 32'h8);
        set_a(1'b0, 2'd0, 32'h0, 32'h0);
        tick_a();
        chk("resume_pc", ifa.pc, 32'hC);
        tick_a();
        chk("seq_inst4", ifa.if_id_inst, 32'h4);

        // Branch to 0x40
        set_a(1'b0, 2'd1, 32'h40, 32'h0);
        tick_a();
        chk("br_pc", ifa.pc, 32'h40);
        chk("br_valid", {31'b0, ifa.if_id_valid}, 32'h0);
        set_a(1'b0, 2'd0, 32'h0, 32'h0);
        tick_a();
        chk("br_pc4", ifa.if_id_pc4, 32'h44);
        chk("br_inst", ifa.if_id_inst, 32'h11);

        // Jump with unaligned target, then stall masking a branch
        set_a(1'b0, 2'd2, 32'h0, 32'h123);
        tick_a();
        chk("jmp_pc", ifa.pc, 32'h120);
        set_a(1'b0, 2'd0, 32'h0, 32'h0);
        tick_a();
        set_a(1'b1, 2'd1, 32'h80, 32'h0);
        tick_a();
        chk("stall_nobr_pc", ifa.pc, 32'h124);
        set_a(1'b0, 2'd0, 32'h0, 32'h0);
        tick_a();
        chk("after_stall_pc", ifa.pc, 32'h128);

        // Illegal instruction: halt for 10 cycles regardless of inputs
        set_a(1'b0, 2'd3, 32'h0, 32'h0);
        tick_a();
        frozen_pc = ifa.pc;
        chk("halt_flag", {31'b0, ifa.halted}, 32'h1);
        for (int i = 0; i < 10; i++) begin
            set_a(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
            tick_a();
        end
        chk("halt_pc", ifa.pc, frozen_pc);
        chk("halt_valid", {31'b0, ifa.if_id_valid}, 32'h0);
        rst_a = 1'b1;
        tick_a();
        rst_a = 1'b0;
        chk("unhalt_pc", ifa.pc, 32'h0);
        chk("unhalt_flag", {31'b0, ifa.halted}, 32'h0);

        // Randomized run against the model
        for (int i = 0; i < 800; i++) begin
            rst_a = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 149) == 0);
            r = $urandom_range(0, 59);
            set_a(m_first ? 1'b0 : ($urandom_range(0, 3) == 0),
                  (r == 0) ? 2'd3 : (r < 6) ? 2'd1 : (r < 10) ? 2'd2 : 2'd0,
                  $urandom_range(0, 1023), $urandom);
            tick_a();
        end

        // Second instance: PC wrap from 0xFFFF_FFFC and perf counters
        rst_a = 1'b1;
        set_a(1'b0, 2'd0, 32'h0, 32'h0);
        tick();
        chk("b_rst_pc", ifb.pc, 32'hFFFF_FFFC);
        rst_b = 1'b0;
        tick();
        chk("b_wrap_pc", ifb.pc, 32'h0);
        chk("b_wrap_pc4", ifb.if_id_pc4, 32'h0);
        chk("b_wrap_inst", ifb.if_id_inst, 32'h100);
        tick();
        chk("b_pc4", ifb.pc, 32'h4);
        chk("b_inst1", ifb.if_id_inst, 32'h1);
        tick();
        ifb.pcsource = 2'd1;
        ifb.bpc = 32'h40;
        tick();
        chk("b_br_pc", ifb.pc, 32'h40);
        chk("b_br_valid", {31'b0, ifb.if_id_valid}, 32'h0);
`ifdef IF_PERF_CNT_EN
        chk("b_perf_fetch", ifb.perf_fetch, 32'd3);
        chk("b_perf_bubble", ifb.perf_bubble, 32'd1);
`endif
        ifb.pcsource = 2'd0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
